// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU operation codes, widths and issue-controller state encoding
package fpu_pkg;

    localparam int FP_W = 32;

    localparam logic [1:0] FPU_ADD = 2'd0;
    localparam logic [1:0] FPU_SUB = 2'd1;
    localparam logic [1:0] FPU_MUL = 2'd2;
    localparam logic [1:0] FPU_CMP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fpu_state_e;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic [1:0]      sel;
    } fpu_op_t;

    // Counter must hold LATENCY-1; one extra code keeps LATENCY=1 at a legal width.
    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - request, FPU operand/result and response signals of the issue controller
interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 4
) ();
    import fpu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [FP_W-1:0]   req_a;
    logic [FP_W-1:0]   req_b;
    logic [1:0]        req_sel;
    logic [TAG_W-1:0]  req_tag;

    logic [FP_W-1:0]   fpu_a;
    logic [FP_W-1:0]   fpu_b;
    logic [1:0]        fpu_sel;
    logic [FP_W-1:0]   fpu_out;

    logic              res_valid;
    logic              res_ready;
    logic [FP_W-1:0]   res_data;
    logic [TAG_W-1:0]  res_tag;

    logic              busy;
    logic [15:0]       op_count;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, req_tag, fpu_out, res_ready,
        output req_ready, fpu_a, fpu_b, fpu_sel, res_valid, res_data, res_tag, busy, op_count
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, req_tag, fpu_out, res_ready,
        input  req_ready, fpu_a, fpu_b, fpu_sel, res_valid, res_data, res_tag, busy, op_count
    );

endinterface

// File: rtl/fpu_lat_counter.sv
// rtl/fpu_lat_counter.sv - loadable down-counter with zero flag that times the FPU latency
module fpu_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Saturates at zero so the capture cycle never wraps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - drives FPU operands for a fixed latency and returns the tagged result
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LATENCY = 6,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_issue_ctrl_if.slave   bus
);

    localparam int CW = lat_cnt_w(LATENCY);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

    fpu_state_e        state;
    fpu_op_t           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [FP_W-1:0]   res_data_q;
    logic [TAG_W-1:0]  res_tag_q;
    logic              res_valid_q;
    logic              busy_q;
    logic [15:0]       op_count_q;

    logic              req_ready_c;
    logic              accept;
    logic [CW-1:0]     cnt;
    logic              cnt_zero;

    // In DONE a new request may only enter when the current result leaves.
    always_comb begin
        req_ready_c = 1'b0;
        case (state)
            IDLE:    req_ready_c = 1'b1;
            DONE:    req_ready_c = bus.res_ready;
            default: req_ready_c = 1'b0;
        endcase
    end

    assign accept = bus.req_valid && req_ready_c;

    fpu_lat_counter #(.W(CW)) u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .dec      (state == BUSY),
        .load_val (LOAD_VAL),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op_q.a   <= bus.req_a;
            op_q.b   <= bus.req_b;
            op_q.sel <= bus.req_sel;
            tag_q    <= bus.req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= BUSY;
                        busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        res_data_q  <= bus.fpu_out;
                        res_tag_q   <= tag_q;
                        res_valid_q <= 1'b1;
                        op_count_q  <= op_count_q + 16'd1;
                        busy_q      <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (bus.req_valid) begin
                            state  <= BUSY;
                            busy_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.fpu_a     = op_q.a;
    assign bus.fpu_b     = op_q.b;
    assign bus.fpu_sel   = op_q.sel;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;
    assign bus.busy      = busy_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - scoreboard bench for fpu_issue_ctrl at LATENCY 6 and LATENCY 1
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst6_n = 1'b0;
    logic              rst1_n = 1'b0;
    logic              use1   = 1'b0;
    logic              rand_rr = 1'b0;
    logic              req_valid = 1'b0;
    logic [31:0]       req_a = '0;
    logic [31:0]       req_b = '0;
    logic [1:0]        req_sel = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              res_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_issue_ctrl_if #(.TAG_W(TAG_W)) if6 ();
    fpu_issue_ctrl_if #(.TAG_W(TAG_W)) if1 ();

    fpu_issue_ctrl #(.LATENCY(6), .TAG_W(TAG_W)) dut6 (.clk(clk), .rst_n(rst6_n), .bus(if6));
    fpu_issue_ctrl #(.LATENCY(1), .TAG_W(TAG_W)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1));

    assign if6.req_valid = req_valid;
    assign if6.req_a     = req_a;
    assign if6.req_b     = req_b;
    assign if6.req_sel   = req_sel;
    assign if6.req_tag   = req_tag;
    assign if6.res_ready = res_ready;
    assign if1.req_valid = req_valid;
    assign if1.req_a     = req_a;
    assign if1.req_b     = req_b;
    assign if1.req_sel   = req_sel;
    assign if1.req_tag   = req_tag;
    assign if1.res_ready = res_ready;

    // Behavioural FPU: normal numbers via double precision, exact for the operands used here.
    function automatic logic [63:0] sp2dp(input logic [31:0] x);
        if (x[30:0] == 31'd0) return {x[31], 63'd0};
        return {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] dp2sp(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        real ra, rb, r;
        ra = $bitstoreal(sp2dp(a));
        rb = $bitstoreal(sp2dp(b));
        case (sel)
            FPU_ADD: r = ra + rb;
            FPU_SUB: r = ra - rb;
            FPU_MUL: r = ra * rb;
            default: return (ra < rb) ? 32'd1 : ((ra > rb) ? 32'd2 : 32'd0);
        endcase
        return dp2sp($realtobits(r));
    endfunction

    function automatic logic [31:0] int2sp(input int n);
        return dp2sp($realtobits(real'(n)));
    endfunction

    logic [31:0] f6_comb;
    logic [31:0] f6_dly [1:5];
    assign f6_comb = fpu_model(if6.fpu_a, if6.fpu_b, if6.fpu_sel);
    always @(posedge clk) begin
        f6_dly[1] <= f6_comb;
        for (int i = 2; i <= 5; i++) f6_dly[i] <= f6_dly[i-1];
    end
    assign if6.fpu_out = f6_dly[5];
    assign if1.fpu_out = fpu_model(if1.fpu_a, if1.fpu_b, if1.fpu_sel);

    logic              m_rst_n, m_req_ready, m_res_valid;
    logic [31:0]       m_res_data;
    logic [TAG_W-1:0]  m_res_tag;
    int                m_lat;
    assign m_rst_n     = use1 ? rst1_n : rst6_n;
    assign m_req_ready = use1 ? if1.req_ready : if6.req_ready;
    assign m_res_valid = use1 ? if1.res_valid : if6.res_valid;
    assign m_res_data  = use1 ? if1.res_data : if6.res_data;
    assign m_res_tag   = use1 ? if1.res_tag : if6.res_tag;
    assign m_lat       = use1 ? 1 : 6;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } sb_t;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } res_t;

    sb_t              sb_q[$];
    res_t             res_log[$];
    int               cyc = 0;
    bit               pend = 1'b0;
    int               pend_cyc = 0;
    logic [TAG_W-1:0] pend_tag = '0;
    int               n_acc = 0;
    int               n_pop = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (m_rst_n) begin
                if (pend && cyc == pend_cyc + m_lat)
                    check("busy_no_res", 32'(m_res_valid), 32'd0);
                if (pend && cyc == pend_cyc + m_lat + 1) begin
                    check("lat_valid", 32'(m_res_valid), 32'd1);
                    check("lat_tag", 32'(m_res_tag), 32'(pend_tag));
                    pend = 1'b0;
                end
                if (m_res_valid && res_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_empty", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_data", m_res_data, e.data);
                        check("sb_tag", 32'(m_res_tag), 32'(e.tag));
                    end
                    res_log.push_back('{data: m_res_data, tag: m_res_tag, cyc: cyc});
                    n_pop++;
                end
                if (req_valid && m_req_ready) begin
                    sb_q.push_back('{data: fpu_model(req_a, req_b, req_sel), tag: req_tag});
                    pend     = 1'b1;
                    pend_cyc = cyc;
                    pend_tag = req_tag;
                    n_acc++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rr) res_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                         input logic [TAG_W-1:0] tag, output bit in_done);
        int t;
        bit got;
        t = 0;
        got = 1'b0;
        in_done = 1'b0;
        req_a = a;
        req_b = b;
        req_sel = sel;
        req_tag = tag;
        req_valid = 1'b1;
        while (!got && t < 300) begin
            @(negedge clk);
            if (m_req_ready) begin
                got = 1'b1;
                in_done = m_res_valid;
            end
            t++;
        end
        check("issue_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (res_log.size() < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("wait_result", 32'(res_log.size() >= n), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d;
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(if6.req_ready), 32'd1);
        check("rst_res_valid", 32'(if6.res_valid), 32'd0);
        check("rst_res_data", if6.res_data, 32'd0);
        check("rst_res_tag", 32'(if6.res_tag), 32'd0);
        check("rst_busy", 32'(if6.busy), 32'd0);
        check("rst_op_count", 32'(if6.op_count), 32'd0);
        check("rst_fpu_a", if6.fpu_a, 32'd0);
        check("rst_fpu_b", if6.fpu_b, 32'd0);
        check("rst_fpu_sel", 32'(if6.fpu_sel), 32'd0);
        rst6_n = 1'b1;
        @(posedge clk);
        #1;

        // abort three cycles into BUSY
        issue(32'h3F800000, 32'h40000000, FPU_ADD, 4'd5, d);
        repeat (3) @(posedge clk);
        #2;
        rst6_n = 1'b0;
        sb_q.delete();
        pend = 1'b0;
        #1;
        check("abort_busy", 32'(if6.busy), 32'd0);
        check("abort_res_valid", 32'(if6.res_valid), 32'd0);
        check("abort_op_count", 32'(if6.op_count), 32'd0);
        check("abort_fpu_a", if6.fpu_a, 32'd0);
        check("abort_fpu_b", if6.fpu_b, 32'd0);
        check("abort_res_tag", 32'(if6.res_tag), 32'd0);
        @(posedge clk);
        #1;
        rst6_n = 1'b1;

        issue(32'h41B80000, 32'h41B80000, FPU_ADD, 4'd3, d);
        wait_log(1);
        check("add_data", res_log[0].data, 32'h42380000);
        check("add_tag", 32'(res_log[0].tag), 32'd3);
        check("add_op_count", 32'(if6.op_count), 32'd1);

        issue(32'h41B80000, 32'h41B80000, FPU_SUB, 4'd4, d);
        issue(32'h41B80000, 32'h41B80000, FPU_MUL, 4'd6, d);
        check("b2b_in_done", 32'(d), 32'd1);
        wait_log(3);
        check("sub_data", res_log[1].data, 32'h00000000);
        check("mul_data", res_log[2].data, 32'h44044000);
        check("b2b_gap", 32'(res_log[2].cyc - res_log[1].cyc), 32'd7);

        // result held under back-pressure with a second request waiting
        res_ready = 1'b0;
        issue(32'h40400000, 32'h40A00000, FPU_MUL, 4'd7, d);
        req_a = 32'h41200000;
        req_b = 32'h3F800000;
        req_sel = FPU_ADD;
        req_tag = 4'd8;
        req_valid = 1'b1;
        t = 0;
        while (!if6.res_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_res_seen", 32'(if6.res_valid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp_res_valid", 32'(if6.res_valid), 32'd1);
            check("bp_res_data", if6.res_data, 32'h41700000);
            check("bp_req_ready", 32'(if6.req_ready), 32'd0);
            check("bp_fpu_a", if6.fpu_a, 32'h40400000);
            check("bp_fpu_b", if6.fpu_b, 32'h40A00000);
            check("bp_fpu_sel", 32'(if6.fpu_sel), 32'(FPU_MUL));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(if6.req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_next_busy", 32'(if6.busy), 32'd1);
        check("bp_next_fpu_a", if6.fpu_a, 32'h41200000);
        wait_log(5);
        check("bp_next_data", res_log[4].data, 32'h41300000);

        issue(32'h41B80000, 32'h41B80001, FPU_CMP, 4'd9, d);
        repeat (6) begin
            check("cmp_busy", 32'(if6.busy), 32'd1);
            check("cmp_fpu_sel", 32'(if6.fpu_sel), 32'd3);
            @(posedge clk);
            #1;
        end
        wait_log(6);
        check("cmp_data", res_log[5].data, 32'd1);
        check("cmp_tag", 32'(res_log[5].tag), 32'd9);
        check("final_op_count6", 32'(if6.op_count), 32'd6);

        // LATENCY=1 instance with random traffic and random back-pressure
        rst6_n = 1'b0;
        use1 = 1'b1;
        sb_q.delete();
        pend = 1'b0;
        n_acc = 0;
        n_pop = 0;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        rand_rr = 1'b1;
        for (int i = 0; i < 256; i++) begin
            issue(int2sp(int'($urandom_range(0, 1000))), int2sp(int'($urandom_range(0, 1000))),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rr = 1'b0;
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        t = 0;
        while (n_pop < 256 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("l1_accepted", 32'(n_acc), 32'd256);
        check("l1_returned", 32'(n_pop), 32'd256);
        check("l1_sb_empty", 32'(sb_q.size()), 32'd0);
        check("l1_op_count", 32'(if1.op_count), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequencer that sits between the pipeline's execute stage and the FPU, acting as the initiator side of the FPU operand/result interface. It accepts one floating-point request at a time over a valid/ready handshake and drives the FPU's A, B and Sel inputs, holding them stable for the FPU's fixed latency. It then captures the FPU output and returns it with its tag over a second valid/ready handshake. This replaces hand-timed operand driving with a cycle-accurate, back-pressurable controller.

Parameters:
LATENCY, 6, clk cycles from operands applied to FPU output valid; legal range 1..15
TAG_W, 4, width of the request tag carried through to the result

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_a  input  32  operand A, IEEE-754 single
req_b  input  32  operand B, IEEE-754 single
req_sel  input  2  0=add, 1=sub, 2=mul, 3=cmp
req_tag  input  TAG_W  opaque request id
fpu_a  output  32  to FPU A
fpu_b  output  32  to FPU B
fpu_sel  output  2  to FPU Sel
fpu_out  input  32  FPU Out_0
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  32  captured FPU result
res_tag  output  TAG_W  tag of the request that produced res_data
busy  output  1  operation in flight (state BUSY)
op_count  output  16  completed operations, wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync-released internally by the flop clocking): state=IDLE; cnt=0; fpu_a=fpu_b=0; fpu_sel=0; res_valid=0; res_data=0; res_tag=0; op_count=0; busy=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch a/b/sel/tag into fpu_a/fpu_b/fpu_sel and the tag register, load cnt=LATENCY-1, and go to BUSY.
  - BUSY: req_ready=0 and busy=1; fpu_* are held constant. Decrement cnt each cycle. In the cycle with cnt==0, capture fpu_out into res_data and the tag into res_tag, set res_valid=1, increment op_count, and go to DONE.
  - DONE: res_valid=1, with res_data/res_tag stable until accepted. On res_ready, clear res_valid.
    - If req_valid in the same cycle, accept the new request (req_ready=res_ready in DONE) and go directly to BUSY.
    - Otherwise go to IDLE.
- Latency: request accepted at edge N; result visible (res_valid=1) after edge N+LATENCY. Back-to-back throughput is one op per LATENCY+1 cycles with res_ready held high.
- fpu_* retain the last issued operands in IDLE and DONE; they are not cleared.
- req_valid while req_ready=0 is ignored. The requester must hold the request, and no state changes.
- The FPU result is passed through unmodified; no rounding or exception handling is done here.
- rst_n asserted mid-BUSY or mid-DONE aborts the operation: the result is discarded, the reset values apply immediately, and op_count is not incremented.
- op_count increments on capture, not on consumption.
- LATENCY=1: BUSY lasts exactly one cycle (cnt loaded with 0).

Decomposition:
- Shared package fpu_pkg holds the localparams FPU_ADD=2'd0, FPU_SUB=2'd1, FPU_MUL=2'd2, FPU_CMP=2'd3, the FP_W=32 constant, and the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- One natural sub-module is fpu_lat_counter: a loadable down-counter with a zero flag, width $clog2(LATENCY+1).
- The FSM and the result register remain in the top module.
- The FPU itself is instantiated by the parent, not inside this block.

Test Plan:
- Add:
  - Stimulus: reset, then req a=0x41B80000, b=0x41B80000, sel=0, tag=3, res_ready=1, real FPU attached.
  - Required response: res_valid exactly 6 cycles after acceptance, res_data=0x42380000, res_tag=3, op_count=1.
- Sub and mul back-to-back:
  - Stimulus: sel=1 with the same operands, then immediately sel=2.
  - Required response: res_data=0x00000000, then 0x44044000.
  - Required response: the second request is accepted in the DONE cycle; the results are 7 cycles apart.
- Back-pressure:
  - Stimulus: hold res_ready=0 for 10 cycles after the result, with req_valid=1 pending.
  - Required response: res_valid and res_data stable, req_ready=0, and fpu_* unchanged throughout.
  - Required response: on res_ready=1 the pending request is accepted in that same cycle.
- Cmp:
  - Stimulus: a=0x41B80000, b=0x41B80001, sel=3.
  - Required response: res_data equals the FPU's Out_0 at the capture cycle, compared against a behavioural FPU model.
  - Required response: fpu_sel=3 is held for all 6 BUSY cycles.
- Reset mid-op:
  - Stimulus: drop rst_n 3 cycles into BUSY.
  - Required response: all outputs return to their reset values asynchronously; op_count stays at its prior value of 0.
  - Required response: after release, a fresh request completes normally.
- LATENCY=1 build:
  - Stimulus: 256 random requests with random res_ready.
  - Required response: each result appears 1 cycle after acceptance with the correct tag.
  - Required response: op_count=256, and no request is lost or duplicated (checked by scoreboard).
